// File: rtl/cotm32_pkg.sv
// Shared trap definitions: mcause codes, cause layout and arbiter FSM states.
// Pure declarations, no latency; no flow control.
// Used by trap_arbiter and irq_edge_latch.
package cotm32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } trap_state_e;

  typedef struct packed {
    logic        intr;
    logic [30:0] code;
  } cause_t;

  localparam logic [30:0] EXC_IADDR_MIS = 31'd0;
  localparam logic [30:0] EXC_ILLEGAL   = 31'd2;
  localparam logic [30:0] EXC_EBREAK    = 31'd3;
  localparam logic [30:0] EXC_LADDR_MIS = 31'd4;
  localparam logic [30:0] EXC_SADDR_MIS = 31'd6;
  localparam logic [30:0] EXC_ECALL     = 31'd11;

  localparam logic [30:0] IRQ_SW    = 31'd3;
  localparam logic [30:0] IRQ_TIMER = 31'd7;
  localparam logic [30:0] IRQ_EXT   = 31'd11;

  // Bit positions inside the {ext,timer,sw} mip/mie views
  localparam int IRQ_BIT_SW    = 0;
  localparam int IRQ_BIT_TIMER = 1;
  localparam int IRQ_BIT_EXT   = 2;

  function automatic cause_t mk_cause(input logic intr, input logic [30:0] code);
    cause_t c;
    c.intr = intr;
    c.code = code;
    return c;
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge pending latch for an interrupt line, cleared by claim (set wins).
// Latency: 1 clock, or 3 clocks with COTM32_EXT_IRQ_SYNC_EN (2-flop sync first).
// No backpressure: pending holds until claimed.
module irq_edge_latch
  import cotm32_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic irq,
  input  logic claim,
  output logic pending
);

  logic irq_cond;
  logic irq_prev;
  logic rise;

`ifdef COTM32_EXT_IRQ_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= irq;
      sync_2 <= sync_1;
    end
  end

  assign irq_cond = sync_2;
`else
  assign irq_cond = irq;
`endif

  assign rise = irq_cond & ~irq_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_prev <= irq_cond;
      // A new edge in the claim cycle must not be lost
      if (rise)
        pending <= 1'b1;
      else if (claim)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/trap_arbiter.sv
// Prioritises exceptions over interrupts, pulses one trap request and kills the pipe.
// Latency: o_trap_req 1 clock after the winning input; 2-cycle lockout (ISSUE, HOLDOFF).
// Inputs ignored outside IDLE; optional COTM32_EXT_IRQ_SYNC_EN syncs i_irq_mext.
module trap_arbiter
  import cotm32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_exc_iaddr_mis,
  input  logic        i_exc_illegal,
  input  logic        i_exc_ecall,
  input  logic        i_exc_ebreak,
  input  logic        i_exc_laddr_mis,
  input  logic        i_exc_saddr_mis,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_exc_addr,
  input  logic [31:0] i_exc_instr,
  input  logic        i_irq_msw,
  input  logic        i_irq_mtimer,
  input  logic        i_irq_mext,
  input  logic        i_ext_claim,
  input  logic        i_mstatus_mie,
  input  logic [2:0]  i_mie,
  input  logic        i_trap_mode,
  output logic        o_trap_req,
  output logic [31:0] o_trap_cause,
  output logic [31:0] o_trap_tval,
  output logic [31:0] o_trap_epc,
  output logic        o_flush,
  output logic [2:0]  o_irq_pending
);

  trap_state_e state_q, state_d;

  logic       ext_pending;
  logic [2:0] irq_eligible;
  logic       exc_any;
  logic       take;
  logic       capture;
  cause_t     cause_sel;
  logic [31:0] tval_sel;
  cause_t     cause_q;
  logic [31:0] tval_q;
  logic [31:0] epc_q;

  irq_edge_latch u_ext_latch (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .irq     (i_irq_mext),
    .claim   (i_ext_claim),
    .pending (ext_pending)
  );

  assign o_irq_pending = {ext_pending, i_irq_mtimer, i_irq_msw};
  assign irq_eligible  = o_irq_pending & i_mie & {3{i_mstatus_mie & ~i_trap_mode}};

  assign exc_any = i_exc_iaddr_mis | i_exc_illegal | i_exc_ecall |
                   i_exc_ebreak | i_exc_laddr_mis | i_exc_saddr_mis;
  assign take    = exc_any | (|irq_eligible);

  // Exceptions are unconditional and outrank every interrupt
  always_comb begin
    cause_sel = '0;
    tval_sel  = '0;
    if (i_exc_iaddr_mis) begin
      cause_sel = mk_cause(1'b0, EXC_IADDR_MIS);
      tval_sel  = i_exc_addr;
    end else if (i_exc_illegal) begin
      cause_sel = mk_cause(1'b0, EXC_ILLEGAL);
      tval_sel  = i_exc_instr;
    end else if (i_exc_ecall) begin
      cause_sel = mk_cause(1'b0, EXC_ECALL);
    end else if (i_exc_ebreak) begin
      cause_sel = mk_cause(1'b0, EXC_EBREAK);
    end else if (i_exc_laddr_mis) begin
      cause_sel = mk_cause(1'b0, EXC_LADDR_MIS);
      tval_sel  = i_exc_addr;
    end else if (i_exc_saddr_mis) begin
      cause_sel = mk_cause(1'b0, EXC_SADDR_MIS);
      tval_sel  = i_exc_addr;
    end else if (irq_eligible[IRQ_BIT_EXT]) begin
      cause_sel = mk_cause(1'b1, IRQ_EXT);
    end else if (irq_eligible[IRQ_BIT_SW]) begin
      cause_sel = mk_cause(1'b1, IRQ_SW);
    end else if (irq_eligible[IRQ_BIT_TIMER]) begin
      cause_sel = mk_cause(1'b1, IRQ_TIMER);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_ISSUE;
          capture = 1'b1;
        end
      end
      ST_ISSUE:   state_d = ST_HOLDOFF;
      ST_HOLDOFF: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cause_q <= '0;
      tval_q  <= '0;
      epc_q   <= '0;
    end else if (capture) begin
      cause_q <= cause_sel;
      tval_q  <= tval_sel;
      epc_q   <= i_pc;
    end
  end

  // Decoded straight from the state register so reset drops them immediately
  assign o_trap_req   = (state_q == ST_ISSUE);
  assign o_flush      = (state_q == ST_ISSUE) || (state_q == ST_HOLDOFF);
  assign o_trap_cause = cause_q;
  assign o_trap_tval  = tval_q;
  assign o_trap_epc   = epc_q;

endmodule

// File: tb/tb_trap_arbiter.sv
// Directed bench for trap_arbiter: vector table for priority/cause/tval, plus
// hand sequences for external IRQ latching, reset during ISSUE and held exceptions.
module tb_trap_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_exc_iaddr_mis, i_exc_illegal, i_exc_ecall;
  logic        i_exc_ebreak, i_exc_laddr_mis, i_exc_saddr_mis;
  logic [31:0] i_pc, i_exc_addr, i_exc_instr;
  logic        i_irq_msw, i_irq_mtimer, i_irq_mext, i_ext_claim;
  logic        i_mstatus_mie;
  logic [2:0]  i_mie;
  logic        i_trap_mode;
  logic        o_trap_req;
  logic [31:0] o_trap_cause, o_trap_tval, o_trap_epc;
  logic        o_flush;
  logic [2:0]  o_irq_pending;

  int total = 0;
  int bad   = 0;

`ifdef COTM32_EXT_IRQ_SYNC_EN
  localparam int EXT_LAT = 2;
`else
  localparam int EXT_LAT = 0;
`endif

  trap_arbiter dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_exc_iaddr_mis (i_exc_iaddr_mis),
    .i_exc_illegal   (i_exc_illegal),
    .i_exc_ecall     (i_exc_ecall),
    .i_exc_ebreak    (i_exc_ebreak),
    .i_exc_laddr_mis (i_exc_laddr_mis),
    .i_exc_saddr_mis (i_exc_saddr_mis),
    .i_pc            (i_pc),
    .i_exc_addr      (i_exc_addr),
    .i_exc_instr     (i_exc_instr),
    .i_irq_msw       (i_irq_msw),
    .i_irq_mtimer    (i_irq_mtimer),
    .i_irq_mext      (i_irq_mext),
    .i_ext_claim     (i_ext_claim),
    .i_mstatus_mie   (i_mstatus_mie),
    .i_mie           (i_mie),
    .i_trap_mode     (i_trap_mode),
    .o_trap_req      (o_trap_req),
    .o_trap_cause    (o_trap_cause),
    .o_trap_tval     (o_trap_tval),
    .o_trap_epc      (o_trap_epc),
    .o_flush         (o_flush),
    .o_irq_pending   (o_irq_pending)
  );

  always #5 i_clk = ~i_clk;

  // exc bits: [0]iaddr [1]illegal [2]ecall [3]ebreak [4]laddr [5]saddr
  typedef struct {
    logic [5:0]  exc;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        msw;
    logic        mtimer;
    logic        gie;
    logic [2:0]  mie;
    logic        tm;
    logic        exp_req;
    logic [31:0] exp_cause;
    logic [31:0] exp_tval;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mkv(input logic [5:0] exc, input logic [31:0] pc,
                               input logic [31:0] addr, input logic [31:0] instr,
                               input logic msw, input logic mtimer, input logic gie,
                               input logic [2:0] mie, input logic tm, input logic exp_req,
                               input logic [31:0] exp_cause, input logic [31:0] exp_tval);
    vec_t v;
    v.exc = exc; v.pc = pc; v.addr = addr; v.instr = instr;
    v.msw = msw; v.mtimer = mtimer; v.gie = gie; v.mie = mie; v.tm = tm;
    v.exp_req = exp_req; v.exp_cause = exp_cause; v.exp_tval = exp_tval;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_exc_iaddr_mis = 0; i_exc_illegal = 0; i_exc_ecall = 0;
    i_exc_ebreak = 0; i_exc_laddr_mis = 0; i_exc_saddr_mis = 0;
    i_pc = 0; i_exc_addr = 0; i_exc_instr = 0;
    i_irq_msw = 0; i_irq_mtimer = 0;
    i_mstatus_mie = 0; i_mie = 3'b000; i_trap_mode = 0;
  endtask

  task automatic apply(input vec_t v);
    i_exc_iaddr_mis = v.exc[0]; i_exc_illegal = v.exc[1]; i_exc_ecall = v.exc[2];
    i_exc_ebreak = v.exc[3]; i_exc_laddr_mis = v.exc[4]; i_exc_saddr_mis = v.exc[5];
    i_pc = v.pc; i_exc_addr = v.addr; i_exc_instr = v.instr;
    i_irq_msw = v.msw; i_irq_mtimer = v.mtimer;
    i_mstatus_mie = v.gie; i_mie = v.mie; i_trap_mode = v.tm;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic got;

    clear_inputs();
    i_irq_mext = 0; i_ext_claim = 0;
    i_rst = 1;
    repeat (2) step();
    chk("rst_req",   {31'd0, o_trap_req}, 32'd0);
    chk("rst_flush", {31'd0, o_flush},    32'd0);
    chk("rst_cause", o_trap_cause, 32'd0);
    chk("rst_tval",  o_trap_tval,  32'd0);
    chk("rst_epc",   o_trap_epc,   32'd0);
    chk("rst_pend",  {29'd0, o_irq_pending}, 32'd0);
    @(negedge i_clk); i_rst = 0;

    //            exc       pc           addr          instr         sw tm gie mie    tm req cause         tval
    vecs[0]  = mkv(6'b000110, 32'h100, 32'h0,          32'hFFFFFFFF, 0, 0, 0, 3'b000, 0, 1, 32'd2,        32'hFFFFFFFF);
    vecs[1]  = mkv(6'b000000, 32'h200, 32'h0,          32'h0,        0, 1, 1, 3'b010, 0, 1, 32'h80000007, 32'h0);
    vecs[2]  = mkv(6'b000000, 32'h204, 32'h0,          32'h0,        0, 1, 1, 3'b010, 1, 0, 32'h0,        32'h0);
    vecs[3]  = mkv(6'b010000, 32'h300, 32'h1003,       32'h0,        1, 0, 1, 3'b001, 0, 1, 32'd4,        32'h1003);
    vecs[4]  = mkv(6'b111111, 32'h400, 32'hAAAA0001,   32'h12345678, 0, 0, 0, 3'b000, 0, 1, 32'd0,        32'hAAAA0001);
    vecs[5]  = mkv(6'b001100, 32'h500, 32'h55,         32'h66,       0, 0, 0, 3'b000, 0, 1, 32'd11,       32'h0);
    vecs[6]  = mkv(6'b101000, 32'h504, 32'h77,         32'h88,       0, 0, 0, 3'b000, 0, 1, 32'd3,        32'h0);
    vecs[7]  = mkv(6'b100000, 32'h508, 32'hDEAD0002,   32'h0,        0, 0, 0, 3'b000, 0, 1, 32'd6,        32'hDEAD0002);
    vecs[8]  = mkv(6'b000000, 32'h50C, 32'h0,          32'h0,        1, 1, 1, 3'b011, 0, 1, 32'h80000003, 32'h0);
    vecs[9]  = mkv(6'b000000, 32'h510, 32'h0,          32'h0,        1, 0, 0, 3'b001, 0, 0, 32'h0,        32'h0);
    vecs[10] = mkv(6'b000000, 32'h514, 32'h0,          32'h0,        0, 1, 1, 3'b001, 0, 0, 32'h0,        32'h0);
    vecs[11] = mkv(6'b000100, 32'h518, 32'h0,          32'h0,        0, 0, 0, 3'b000, 1, 1, 32'd11,       32'h0);
    vecs[12] = mkv(6'b000010, 32'h51C, 32'h9,          32'hCAFEF00D, 1, 1, 1, 3'b111, 0, 1, 32'd2,        32'hCAFEF00D);
    vecs[13] = mkv(6'b000001, 32'h600, 32'h102,        32'h0,        0, 0, 0, 3'b000, 0, 1, 32'd0,        32'h102);

    for (int k = 0; k < NV; k++) begin
      @(negedge i_clk);
      apply(vecs[k]);
      step();
      chk($sformatf("v%0d_req", k),   {31'd0, o_trap_req}, {31'd0, vecs[k].exp_req});
      chk($sformatf("v%0d_flush", k), {31'd0, o_flush},    {31'd0, vecs[k].exp_req});
      if (vecs[k].exp_req) begin
        chk($sformatf("v%0d_cause", k), o_trap_cause, vecs[k].exp_cause);
        chk($sformatf("v%0d_tval", k),  o_trap_tval,  vecs[k].exp_tval);
        chk($sformatf("v%0d_epc", k),   o_trap_epc,   vecs[k].pc);
        @(negedge i_clk); clear_inputs();
        step();
        chk($sformatf("v%0d_hold_req", k),   {31'd0, o_trap_req}, 32'd0);
        chk($sformatf("v%0d_hold_flush", k), {31'd0, o_flush},    32'd1);
        step();
        chk($sformatf("v%0d_idle_flush", k), {31'd0, o_flush},    32'd0);
      end else begin
        @(negedge i_clk); clear_inputs();
      end
    end

    // External interrupt: edge latching, claim, claim coincident with a new edge
    @(negedge i_clk);
    i_irq_mext = 1; i_mie = 3'b100; i_mstatus_mie = 1; i_pc = 32'h800;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = o_trap_req;
    end
    chk("ext_trap_seen", {31'd0, got}, 32'd1);
    chk("ext_cause", o_trap_cause, 32'h8000000B);
    chk("ext_tval",  o_trap_tval,  32'h0);
    chk("ext_epc",   o_trap_epc,   32'h800);
    @(negedge i_clk); i_mstatus_mie = 0;
    repeat (3) step();
    chk("ext_no_retrap", {31'd0, o_trap_req}, 32'd0);
    chk("ext_pend_after_take", {31'd0, o_irq_pending[2]}, 32'd1);
    @(negedge i_clk); i_irq_mext = 0;
    repeat (4) step();
    chk("ext_pend_after_fall", {31'd0, o_irq_pending[2]}, 32'd1);
    @(negedge i_clk); i_ext_claim = 1;
    step();
    chk("ext_claim_clears", {31'd0, o_irq_pending[2]}, 32'd0);
    @(negedge i_clk); i_ext_claim = 0; i_irq_mext = 1;
    repeat (EXT_LAT + 1) step();
    chk("ext_relatch", {31'd0, o_irq_pending[2]}, 32'd1);
    @(negedge i_clk); i_irq_mext = 0;
    repeat (4) step();
    @(negedge i_clk); i_irq_mext = 1;
    repeat (EXT_LAT) @(negedge i_clk);
    i_ext_claim = 1;
    step();
    chk("ext_claim_vs_edge", {31'd0, o_irq_pending[2]}, 32'd1);
    @(negedge i_clk); i_ext_claim = 0; i_irq_mext = 0;
    repeat (4) step();
    chk("ext_still_pending", {31'd0, o_irq_pending[2]}, 32'd1);

    // Reset during ISSUE with ext pending still set
    @(negedge i_clk); i_exc_ecall = 1; i_pc = 32'h900;
    step();
    chk("rstiss_req_before", {31'd0, o_trap_req}, 32'd1);
    @(negedge i_clk); i_rst = 1; i_exc_ecall = 0;
    step();
    chk("rstiss_req",   {31'd0, o_trap_req}, 32'd0);
    chk("rstiss_flush", {31'd0, o_flush},    32'd0);
    chk("rstiss_pend",  {31'd0, o_irq_pending[2]}, 32'd0);
    chk("rstiss_cause", o_trap_cause, 32'd0);
    chk("rstiss_epc",   o_trap_epc,   32'd0);
    @(negedge i_clk); i_rst = 0;
    step();
    chk("rstiss_after_req", {31'd0, o_trap_req}, 32'd0);

    // Exception held high: one pulse per IDLE entry, inputs ignored in between
    @(negedge i_clk); i_exc_illegal = 1; i_exc_instr = 32'h0BAD0BAD; i_pc = 32'h700;
    pulses = 0;
    step(); pulses += int'(o_trap_req);
    chk("held_e1_req",   {31'd0, o_trap_req}, 32'd1);
    chk("held_e1_cause", o_trap_cause, 32'd2);
    chk("held_e1_epc",   o_trap_epc,   32'h700);
    @(negedge i_clk); i_pc = 32'h704; i_exc_iaddr_mis = 1; i_exc_addr = 32'h33;
    step(); pulses += int'(o_trap_req);
    chk("held_e2_req",   {31'd0, o_trap_req}, 32'd0);
    chk("held_e2_cause", o_trap_cause, 32'd2);
    chk("held_e2_epc",   o_trap_epc,   32'h700);
    @(negedge i_clk); i_exc_iaddr_mis = 0;
    step(); pulses += int'(o_trap_req);
    chk("held_e3_flush", {31'd0, o_flush}, 32'd0);
    chk("held_e3_epc",   o_trap_epc, 32'h700);
    step(); pulses += int'(o_trap_req);
    chk("held_e4_req",   {31'd0, o_trap_req}, 32'd1);
    chk("held_e4_epc",   o_trap_epc, 32'h704);
    chk("held_e4_tval",  o_trap_tval, 32'h0BAD0BAD);
    for (int i = 0; i < 5; i++) begin
      step(); pulses += int'(o_trap_req);
    end
    chk("held_pulse_count", pulses, 32'd3);
    @(negedge i_clk); clear_inputs();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_arbiter.md
TRAP_ARBITER -- requirements
Module: trap_arbiter

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock; i_rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have exception inputs, all in 1: i_exc_iaddr_mis, i_exc_illegal, i_exc_ecall, i_exc_ebreak, i_exc_laddr_mis, i_exc_saddr_mis.
REQ-003 SHALL have: i_pc  in  32  PC of faulting/interrupted instr; i_exc_addr  in  32  misaligned address; i_exc_instr  in  32  illegal instr word.
REQ-004 SHALL have: i_irq_msw, i_irq_mtimer  in  1  level IRQs; i_irq_mext  in  1  external IRQ, asynchronous; i_ext_claim  in  1  clears external pending.
REQ-005 SHALL have: i_mstatus_mie  in  1  global enable; i_mie  in  3  per-IRQ enable {ext,timer,sw}; i_trap_mode  in  1  from trap_control.
REQ-006 SHALL have: o_trap_req  out  1  one-cycle pulse to trap_control; o_trap_cause  out  32  mcause; o_trap_tval  out  32  mtval; o_trap_epc  out  32  mepc; o_flush  out  1  pipeline kill; o_irq_pending  out  3  mip view {ext,timer,sw}.

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> HOLDOFF -> IDLE; reset state IDLE.
REQ-008 IDLE: any exception input high -> ISSUE next cycle; else eligible interrupt -> ISSUE; else stay.
REQ-009 ISSUE: o_trap_req=1 exactly one cycle; always -> HOLDOFF.
REQ-010 HOLDOFF: one cycle, lets trap_control register trap mode; always -> IDLE.
REQ-011 o_flush SHALL be 1 in ISSUE and HOLDOFF, 0 in IDLE.
REQ-012 Exception/IRQ inputs SHALL be ignored outside IDLE; cause/tval/epc SHALL be captured on IDLE->ISSUE and held stable until next capture.
REQ-013 Exception priority high->low: iaddr_mis(0), illegal(2), ecall(11), ebreak(3), laddr_mis(4), saddr_mis(6); cause bit31=0.
REQ-014 Interrupt priority: ext(11) > sw(3) > timer(7); cause bit31=1.
REQ-015 Exceptions SHALL beat interrupts in the same cycle.
REQ-016 Interrupt eligible iff pending & i_mie bit & i_mstatus_mie & !i_trap_mode.
REQ-017 Exceptions SHALL be taken regardless of i_trap_mode or enables.
REQ-018 tval: misaligned -> i_exc_addr; illegal -> i_exc_instr; all else and interrupts -> 0. epc = i_pc for all.
REQ-019 sw/timer pending SHALL mirror levels combinationally; ext pending SHALL set on rising edge of (conditioned) i_irq_mext, clear on i_ext_claim; set and claim same cycle -> stays set.
REQ-020 Taking an interrupt SHALL NOT clear ext pending; only i_ext_claim clears it.

Reset
REQ-021 On i_rst: state IDLE, o_trap_req=0, o_flush=0, cause/tval/epc=0, ext pending=0, edge-detect/sync flops=0; reset mid-ISSUE/HOLDOFF aborts without pulse.

Configuration
REQ-022 COTM32_EXT_IRQ_SYNC_EN defined: i_irq_mext SHALL pass a 2-flop synchronizer before edge detect (rising edge -> pending after 3 clocks).
REQ-023 Undefined: edge detect SHALL use i_irq_mext directly (pending after 1 clock); no other behaviour change.

Structure
REQ-024 cotm32_pkg SHALL hold exception/interrupt cause code constants, the cause typedef and the FSM state enum.
REQ-025 Sub-module irq_edge_latch (optional sync, edge detect, pending set/clear) is natural; instantiate once for ext.

Verification
REQ-026 i_exc_illegal=1, i_exc_ecall=1, i_exc_instr=0xFFFFFFFF, i_pc=0x100 -> next cycle o_trap_req=1, cause=2, tval=0xFFFFFFFF, epc=0x100.
REQ-027 i_irq_mtimer=1, i_mie=3'b010, mie=1, trap_mode=0 -> cause=0x80000007, tval=0; same with trap_mode=1 -> no o_trap_req.
REQ-028 i_exc_laddr_mis=1 with i_irq_msw enabled same cycle -> cause=4, tval=i_exc_addr; no interrupt issued that cycle.
REQ-029 i_irq_mext 0->1 held, ext enabled -> cause=0x8000000B; pending stays 1 until i_ext_claim; claim coincident with new edge -> pending=1.
REQ-030 i_rst pulsed during ISSUE -> o_trap_req=0 next cycle, state IDLE, o_irq_pending[2]=0.
REQ-031 Exception held high across ISSUE/HOLDOFF -> exactly one pulse per IDLE entry, inputs ignored in between.
